// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Fixed data priority with a bounded streak so a pending fetch cannot starve.
module mem_port_arbiter #(
    parameter int         MEM_LAT    = 1,
    parameter int         STARVE_MAX = 4,
    parameter logic [2:0] IF_DMTYPE  = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_type,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [2:0]  mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        busy
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_n;
    logic          own_d;
    logic [SW-1:0] streak;
    logic [CW-1:0] cnt;
    logic          grant, grant_d, last_wait;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n   = state;
        grant     = 1'b0;
        grant_d   = 1'b0;
        last_wait = (state == WAIT) && (cnt == CW'(MEM_LAT - 1));
        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant   = 1'b1;
                    grant_d = d_req && (!i_req || (streak < SW'(STARVE_MAX)));
                    state_n = ISSUE;
                end
            end
            ISSUE:   state_n = WAIT;
            WAIT:    if (last_wait) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            own_d     <= 1'b0;
            streak    <= '0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_type  <= 3'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            i_rdata   <= 32'd0;
            d_rdata   <= 32'd0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (grant) begin
                own_d  <= grant_d;
                mem_en <= 1'b1;
                if (grant_d) begin
                    mem_we    <= d_we;
                    mem_type  <= d_type;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    streak    <= i_req ? streak + 1'b1 : '0;
                end else begin
                    mem_we   <= 1'b0;
                    mem_type <= IF_DMTYPE;
                    mem_addr <= i_addr;
                    streak   <= '0;
                end
            end
            if (state == ISSUE) cnt <= '0;
            if (state == WAIT)  cnt <= cnt + 1'b1;
            if (last_wait) begin
                if (own_d) begin
                    // stores leave the previous load result visible
                    if (!mem_we) d_rdata <= mem_rdata;
                    d_ready <= 1'b1;
                end else begin
                    i_rdata <= mem_rdata;
                    i_ready <= 1'b1;
                end
            end
        end
    end

    assign stall_if  = rst && i_req && !i_ready;
    assign stall_mem = rst && d_req && !d_ready;
    assign busy      = rst && (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at 3.
// Memory model returns addr ^ 0x00100097 exactly MEM_LAT cycles after mem_en.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [2:0]  d_type;

    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ready, d_ready, mem_en, mem_we, stall_if, stall_mem, busy;
    logic [2:0]  mem_type;

    logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        i_ready3, d_ready3, mem_en3, mem_we3, stall_if3, stall_mem3, busy3;
    logic [2:0]  mem_type3;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_type(mem_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata3), .i_ready(i_ready3),
        .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata3), .d_ready(d_ready3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_type(mem_type3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .stall_if(stall_if3), .stall_mem(stall_mem3), .busy(busy3)
    );

    function automatic logic [31:0] mval(input logic [31:0] a);
        return a ^ 32'h00100097;
    endfunction

    logic        v1 = 1'b0;
    logic [31:0] a1 = '0;
    always @(posedge clk) begin
        v1 <= mem_en;
        a1 <= mem_addr;
    end
    assign mem_rdata = v1 ? mval(a1) : 32'hBADBAD00;

    logic [2:0]  v3 = '0;
    logic [31:0] a3 [3];
    always @(posedge clk) begin
        v3    <= {v3[1:0], mem_en3};
        a3[0] <= mem_addr3;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign mem_rdata3 = v3[2] ? mval(a3[2]) : 32'hBADBAD00;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_type = '0;
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h4; d_addr = 32'h8; d_wdata = '0; d_type = '0;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL rst_stall_if got=%b exp=0", stall_if); end
        checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL rst_stall_mem got=%b exp=0", stall_mem); end
        step();
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
        checks++; if ({i_ready, d_ready} !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", {i_ready, d_ready}); end
        checks++; if (i_rdata !== 32'd0 || d_rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", i_rdata, d_rdata); end
        checks++; if (mem_addr !== 32'd0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        i_req = 1'b0; d_req = 1'b0; rst = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        do_reset();
        i_addr = 32'h4; i_req = 1'b1;
        #1;
        checks++; if (stall_if !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL f_t0 got=%b%b exp=10", stall_if, mem_en); end
        step();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h4 || mem_we !== 1'b0) begin failures++; $display("FAIL f_issue got=%b %h %b exp=1 4 0", mem_en, mem_addr, mem_we); end
        checks++; if (stall_if !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL f_stall1 got=%b%b exp=11", stall_if, busy); end
        step();
        checks++; if (mem_en !== 1'b0 || i_ready !== 1'b0 || stall_if !== 1'b1) begin failures++; $display("FAIL f_wait got=%b%b%b exp=001", mem_en, i_ready, stall_if); end
        step();
        checks++; if (i_ready !== 1'b1 || stall_if !== 1'b0) begin failures++; $display("FAIL f_ready got=%b%b exp=10", i_ready, stall_if); end
        checks++; if (i_rdata !== 32'h00100093) begin failures++; $display("FAIL f_rdata got=%h exp=00100093", i_rdata); end
        i_req = 1'b0;
        step();
        checks++; if (i_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL f_after got=%b%b exp=00", i_ready, busy); end
    endtask

    task automatic test_contend();
        do_reset();
        i_addr = 32'h8; i_req = 1'b1;
        d_addr = 32'h100; d_we = 1'b0; d_type = 3'd0; d_req = 1'b1;
        step();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL c_d_issue got=%b %h exp=1 100", mem_en, mem_addr); end
        step(); step();
        checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin failures++; $display("FAIL c_d_ready got=%b%b exp=10", d_ready, i_ready); end
        checks++; if (d_rdata !== 32'h00100197) begin failures++; $display("FAIL c_d_rdata got=%h exp=00100197", d_rdata); end
        d_req = 1'b0;
        step();
        checks++; if (mem_en !== 1'b0 || stall_if !== 1'b1) begin failures++; $display("FAIL c_gap got=%b%b exp=01", mem_en, stall_if); end
        step();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h8 || mem_type !== 3'd0) begin failures++; $display("FAIL c_i_issue got=%b %h %h exp=1 8 0", mem_en, mem_addr, mem_type); end
        step(); step();
        checks++; if (i_ready !== 1'b1 || i_rdata !== 32'h0010009F) begin failures++; $display("FAIL c_i_ready got=%b %h exp=1 0010009f", i_ready, i_rdata); end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a [6];
        int g;
        int cyc;
        exp_a[0] = 32'h200; exp_a[1] = 32'h200; exp_a[2] = 32'h200;
        exp_a[3] = 32'h200; exp_a[4] = 32'hC;   exp_a[5] = 32'h200;
        do_reset();
        i_addr = 32'hC; i_req = 1'b1;
        d_addr = 32'h200; d_we = 1'b0; d_req = 1'b1;
        g = 0; cyc = 0;
        while (g < 6 && cyc < 40) begin
            step();
            cyc++;
            if (mem_en === 1'b1) begin
                checks++;
                if (mem_addr !== exp_a[g]) begin failures++; $display("FAIL b2b_grant%0d got=%h exp=%h", g, mem_addr, exp_a[g]); end
                g++;
            end
        end
        checks++; if (g != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", g); end
        i_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        do_reset();
        d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_type = 3'b001; d_req = 1'b1;
        step();
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_type !== 3'b001) begin failures++; $display("FAIL s_ctrl got=%b%b %b exp=11 001", mem_en, mem_we, mem_type); end
        checks++; if (mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL s_data got=%h %h exp=20 deadbeef", mem_addr, mem_wdata); end
        step();
        checks++; if (mem_en !== 1'b0 || d_ready !== 1'b0) begin failures++; $display("FAIL s_wait got=%b%b exp=00", mem_en, d_ready); end
        step();
        checks++; if (d_ready !== 1'b1 || stall_mem !== 1'b0) begin failures++; $display("FAIL s_ready got=%b%b exp=10", d_ready, stall_mem); end
        checks++; if (d_rdata !== 32'd0) begin failures++; $display("FAIL s_rdata got=%h exp=0", d_rdata); end
        d_req = 1'b0; d_we = 1'b0;
        step();
        checks++; if (mem_en !== 1'b0 || d_ready !== 1'b0) begin failures++; $display("FAIL s_after got=%b%b exp=00", mem_en, d_ready); end
    endtask

    task automatic test_lat3();
        do_reset();
        i_addr = 32'h40; i_req = 1'b1;
        step();
        checks++; if (mem_en3 !== 1'b1 || mem_addr3 !== 32'h40) begin failures++; $display("FAIL l3_issue got=%b %h exp=1 40", mem_en3, mem_addr3); end
        step(); step(); step();
        checks++; if (i_ready3 !== 1'b0 || stall_if3 !== 1'b1) begin failures++; $display("FAIL l3_early got=%b%b exp=01", i_ready3, stall_if3); end
        step();
        checks++; if (i_ready3 !== 1'b1 || i_rdata3 !== 32'h001000D7) begin failures++; $display("FAIL l3_ready got=%b %h exp=1 001000d7", i_ready3, i_rdata3); end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_rst_wait();
        do_reset();
        i_addr = 32'h10; i_req = 1'b1;
        step();
        checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL rw_issue got=%b exp=1", mem_en); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || stall_if !== 1'b0) begin failures++; $display("FAIL rw_forced got=%b%b exp=00", busy, stall_if); end
        step();
        rst = 1'b1; i_req = 1'b0;
        checks++; if (busy !== 1'b0 || i_ready !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL rw_after got=%b%b%b exp=000", busy, i_ready, mem_en); end
        step();
        checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin failures++; $display("FAIL rw_noready got=%b%b exp=00", i_ready, d_ready); end
        d_addr = 32'h30; d_we = 1'b0; d_req = 1'b1;
        step(); step(); step();
        checks++; if (d_ready !== 1'b1 || d_rdata !== 32'h001000A7) begin failures++; $display("FAIL rw_load got=%b %h exp=1 001000a7", d_ready, d_rdata); end
        d_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contend();
        test_back_to_back();
        test_store();
        test_lat3();
        test_rst_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
